// File: rtl/pwm_pkg.sv
// Shared PWM constants and capture FSM state encoding, common to the
// generator, the capture block and their benches.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_STUCK = 2'd3
   } cap_state_t;

   localparam int unsigned BASE_FREQ  = 32'd50_000_000;
   localparam int unsigned PWM_FREQ   = 32'd50;
   localparam int unsigned PWM_COUNTS = BASE_FREQ / PWM_FREQ;

endpackage

// File: rtl/pwm_capture_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, plus a one-cycle
// delayed copy used to derive single-cycle rise/fall pulses.
module edge_sync #(
   parameter int SYNC_N = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_s,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_N-1:0] r_sync;
   logic              r_s_d;

   // synchronizer chain and delayed copy of its output
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_s_d  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_N-2:0], i_async};
         r_s_d  <= r_sync[SYNC_N-1];
      end
   end

   assign o_s    = r_sync[SYNC_N-1];
   assign o_rise = o_s & ~r_s_d;
   assign o_fall = ~o_s & r_s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rising-to-rising period in clk cycles,
// publishes once per full period, and flags inputs stuck high or low.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 32'd2_000_000,
   parameter int SYNC_N  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             stuck_high,
   output logic             stuck_low
);

   if (SYNC_N < 2) begin : g_chk_sync
      $error("pwm_capture: SYNC_N must be at least 2");
   end
   if ((TIMEOUT < 2) || ((CNT_W < 63) && (64'(TIMEOUT) >= (64'd1 << CNT_W)))) begin : g_chk_timeout
      $error("pwm_capture: TIMEOUT must be >= 2 and fit in CNT_W bits");
   end

   // Timeout fires on the cycle whose increment would make per_acc reach TIMEOUT.
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   cap_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_hi_acc, w_hi_acc_nxt;
   logic [CNT_W-1:0] r_per_acc, w_per_acc_nxt;
   logic [CNT_W-1:0] r_hi_lat, w_hi_lat_nxt;
   logic [CNT_W-1:0] r_high_cnt, w_high_cnt_nxt;
   logic [CNT_W-1:0] r_period_cnt, w_period_cnt_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_stuck_high, w_stuck_high_nxt;
   logic             r_stuck_low, w_stuck_low_nxt;
   logic             w_s, w_rise, w_fall, w_timeout;

   edge_sync #(.SYNC_N(SYNC_N)) u_edge_sync (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_async (pwm_in),
      .o_s     (w_s),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_timeout = (r_per_acc >= TO_LAST);

   // next-state, accumulator and publish logic
   always_comb begin
      w_state_nxt      = r_state;
      w_hi_acc_nxt     = r_hi_acc;
      w_per_acc_nxt    = r_per_acc;
      w_hi_lat_nxt     = r_hi_lat;
      w_high_cnt_nxt   = r_high_cnt;
      w_period_cnt_nxt = r_period_cnt;
      w_valid_nxt      = 1'b0;
      w_stuck_high_nxt = r_stuck_high;
      w_stuck_low_nxt  = r_stuck_low;
      if (!enable) begin
         w_state_nxt      = ST_ARM;
         w_hi_acc_nxt     = '0;
         w_per_acc_nxt    = '0;
         w_hi_lat_nxt     = '0;
         w_stuck_high_nxt = 1'b0;
         w_stuck_low_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_ARM: begin
               if (w_rise) begin
                  w_state_nxt   = ST_HIGH;
                  w_hi_acc_nxt  = ONE;
                  w_per_acc_nxt = ONE;
               end else if (w_timeout && !w_fall) begin
                  w_state_nxt      = ST_STUCK;
                  w_stuck_high_nxt = w_s;
                  w_stuck_low_nxt  = ~w_s;
               end else begin
                  w_per_acc_nxt = r_per_acc + ONE;
               end
            end
            ST_HIGH: begin
               if (w_fall) begin
                  w_state_nxt   = ST_LOW;
                  w_hi_lat_nxt  = r_hi_acc;
                  w_per_acc_nxt = r_per_acc + ONE;
               end else if (w_timeout) begin
                  w_state_nxt      = ST_STUCK;
                  w_stuck_high_nxt = w_s;
                  w_stuck_low_nxt  = ~w_s;
               end else begin
                  w_hi_acc_nxt  = r_hi_acc + ONE;
                  w_per_acc_nxt = r_per_acc + ONE;
               end
            end
            ST_LOW: begin
               if (w_rise) begin
                  w_high_cnt_nxt   = r_hi_lat;
                  w_period_cnt_nxt = r_per_acc;
                  w_valid_nxt      = 1'b1;
                  w_state_nxt      = ST_HIGH;
                  w_hi_acc_nxt     = ONE;
                  w_per_acc_nxt    = ONE;
               end else if (w_timeout) begin
                  w_state_nxt      = ST_STUCK;
                  w_stuck_high_nxt = w_s;
                  w_stuck_low_nxt  = ~w_s;
               end else begin
                  w_per_acc_nxt = r_per_acc + ONE;
               end
            end
            ST_STUCK: begin
               // Leaving via a fall restarts from a clean ARM so the timeout re-arms.
               if (w_rise) begin
                  w_state_nxt      = ST_HIGH;
                  w_hi_acc_nxt     = ONE;
                  w_per_acc_nxt    = ONE;
                  w_stuck_high_nxt = 1'b0;
                  w_stuck_low_nxt  = 1'b0;
               end else if (w_fall) begin
                  w_state_nxt      = ST_ARM;
                  w_hi_acc_nxt     = '0;
                  w_per_acc_nxt    = '0;
                  w_stuck_high_nxt = 1'b0;
                  w_stuck_low_nxt  = 1'b0;
               end else begin
                  w_state_nxt = ST_STUCK;
               end
            end
            default: begin
               w_state_nxt      = ST_ARM;
               w_hi_acc_nxt     = '0;
               w_per_acc_nxt    = '0;
               w_stuck_high_nxt = 1'b0;
               w_stuck_low_nxt  = 1'b0;
            end
         endcase
      end
   end

   // state, accumulators and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_ARM;
         r_hi_acc     <= '0;
         r_per_acc    <= '0;
         r_hi_lat     <= '0;
         r_high_cnt   <= '0;
         r_period_cnt <= '0;
         r_valid      <= 1'b0;
         r_stuck_high <= 1'b0;
         r_stuck_low  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_hi_acc     <= w_hi_acc_nxt;
         r_per_acc    <= w_per_acc_nxt;
         r_hi_lat     <= w_hi_lat_nxt;
         r_high_cnt   <= w_high_cnt_nxt;
         r_period_cnt <= w_period_cnt_nxt;
         r_valid      <= w_valid_nxt;
         r_stuck_high <= w_stuck_high_nxt;
         r_stuck_low  <= w_stuck_low_nxt;
      end
   end

   assign high_cnt   = r_high_cnt;
   assign period_cnt = r_period_cnt;
   assign meas_valid = r_valid;
   assign stuck_high = r_stuck_high;
   assign stuck_low  = r_stuck_low;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a shortened timeout (2000 cycles).
module tb_pwm_capture;

   localparam int CNT_W   = 32;
   localparam int TIMEOUT = 2000;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             enable = 1'b0;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic             meas_valid;
   logic             stuck_high;
   logic             stuck_low;

   int n_chk = 0;
   int n_pass = 0;
   int n_valid = 0;
   int run = 0;
   int max_run = 0;
   int v0 = 0;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_N(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .pwm_in     (pwm_in),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .meas_valid (meas_valid),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low)
   );

   always #5 clk = ~clk;

   // count strobes and the longest run of consecutive strobe cycles
   always @(negedge clk) begin
      if (meas_valid) begin
         n_valid <= n_valid + 1;
         run     <= run + 1;
         if (run + 1 > max_run) max_run <= run + 1;
      end else begin
         run <= 0;
      end
   end

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic wave(input int hi, input int per, input int n);
      for (int k = 0; k < n; k++) begin
         pwm_in = 1'b1;
         tick(hi);
         pwm_in = 1'b0;
         tick(per - hi);
      end
   endtask

   task automatic en_cycle();
      enable = 1'b0;
      tick(2);
      enable = 1'b1;
   endtask

   initial begin
      // reset values
      tick(3);
      check("rst_high_cnt", 64'(high_cnt), 64'd0);
      check("rst_period_cnt", 64'(period_cnt), 64'd0);
      check("rst_valid", 64'(meas_valid), 64'd0);
      check("rst_stuck_high", 64'(stuck_high), 64'd0);
      check("rst_stuck_low", 64'(stuck_low), 64'd0);
      rst = 1'b1;
      enable = 1'b1;

      // 300/1000 for three periods
      v0 = n_valid;
      wave(300, 1000, 3);
      check("t1_nvalid", 64'(n_valid - v0), 64'd2);
      check("t1_high", 64'(high_cnt), 64'd300);
      check("t1_period", 64'(period_cnt), 64'd1000);
      check("t1_stuck_low", 64'(stuck_low), 64'd0);
      en_cycle();

      // 40 % duty, then period one below the timeout
      v0 = n_valid;
      wave(640, 1600, 3);
      check("t2_nvalid", 64'(n_valid - v0), 64'd2);
      check("t2_high", 64'(high_cnt), 64'd640);
      check("t2_period", 64'(period_cnt), 64'd1600);
      en_cycle();
      v0 = n_valid;
      wave(800, 1999, 3);
      check("t2b_stuck_low", 64'(stuck_low), 64'd0);
      en_cycle();
      check("t2b_nvalid", 64'(n_valid - v0), 64'd2);
      check("t2b_high", 64'(high_cnt), 64'd800);
      check("t2b_period", 64'(period_cnt), 64'd1999);

      // narrow pulses
      en_cycle();
      v0 = n_valid;
      wave(3, 10, 5);
      check("t5_nvalid", 64'(n_valid - v0), 64'd4);
      check("t5_high", 64'(high_cnt), 64'd3);
      check("t5_period", 64'(period_cnt), 64'd10);
      en_cycle();
      v0 = n_valid;
      wave(1, 10, 4);
      check("t5b_nvalid", 64'(n_valid - v0), 64'd3);
      check("t5b_high", 64'(high_cnt), 64'd1);
      check("t5b_period", 64'(period_cnt), 64'd10);

      // held low after reset: stuck_low exactly TIMEOUT cycles after arm
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      v0 = n_valid;
      tick(TIMEOUT - 1);
      check("t3_stuck_low_early", 64'(stuck_low), 64'd0);
      tick(1);
      check("t3_stuck_low", 64'(stuck_low), 64'd1);
      check("t3_stuck_high", 64'(stuck_high), 64'd0);
      check("t3_nvalid", 64'(n_valid - v0), 64'd0);
      pwm_in = 1'b1;
      tick(2);
      check("t3_stuck_before_rise", 64'(stuck_low), 64'd1);
      tick(1);
      check("t3_stuck_cleared", 64'(stuck_low), 64'd0);
      tick(297);
      pwm_in = 1'b0;
      tick(700);
      check("t3_no_first_valid", 64'(n_valid - v0), 64'd0);
      wave(300, 1000, 2);
      check("t3_nvalid_after", 64'(n_valid - v0), 64'd2);
      check("t3_high", 64'(high_cnt), 64'd300);
      check("t3_period", 64'(period_cnt), 64'd1000);

      // held high mid-stream
      v0 = n_valid;
      pwm_in = 1'b1;
      tick(2500);
      check("t4_stuck_high", 64'(stuck_high), 64'd1);
      check("t4_stuck_low", 64'(stuck_low), 64'd0);
      check("t4_high_hold", 64'(high_cnt), 64'd300);
      check("t4_period_hold", 64'(period_cnt), 64'd1000);
      check("t4_nvalid", 64'(n_valid - v0), 64'd1);
      pwm_in = 1'b0;
      tick(5);
      check("t4_stuck_high_clear", 64'(stuck_high), 64'd0);

      // reset mid-HIGH
      wave(300, 1000, 2);
      pwm_in = 1'b1;
      tick(100);
      rst = 1'b0;
      #2;
      check("t6_rst_high", 64'(high_cnt), 64'd0);
      check("t6_rst_period", 64'(period_cnt), 64'd0);
      check("t6_rst_valid", 64'(meas_valid), 64'd0);
      tick(1);
      rst = 1'b1;
      pwm_in = 1'b0;
      v0 = n_valid;
      tick(5);
      check("t6_no_spurious", 64'(n_valid - v0), 64'd0);
      wave(300, 1000, 3);
      check("t6_nvalid", 64'(n_valid - v0), 64'd2);
      check("t6_high", 64'(high_cnt), 64'd300);
      check("t6_period", 64'(period_cnt), 64'd1000);

      // enable dropped mid-HIGH
      pwm_in = 1'b1;
      tick(150);
      v0 = n_valid;
      enable = 1'b0;
      tick(3);
      check("t6e_nvalid", 64'(n_valid - v0), 64'd0);
      check("t6e_high_hold", 64'(high_cnt), 64'd300);
      check("t6e_period_hold", 64'(period_cnt), 64'd1000);
      check("t6e_stuck_high", 64'(stuck_high), 64'd0);
      pwm_in = 1'b0;
      tick(3);
      enable = 1'b1;
      wave(250, 900, 3);
      check("t6e_nvalid_after", 64'(n_valid - v0), 64'd2);
      check("t6e_high", 64'(high_cnt), 64'd250);
      check("t6e_period", 64'(period_cnt), 64'd900);

      check("valid_width", 64'(max_run), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
